object_engine: RTL and testbench
================================

# object_engine

Parametrised multi-sprite draw engine, successor to the single-object mover. Holds the position and visibility of `NOBJ` sprites and accepts one show/hide/move command at a time over a valid/ready handshake. For each command it erases the old sprite box to the background colour, updates and clamps the position, and redraws from an external sprite ROM, skipping transparent pixels. It sits between keyboard/control logic and `vga_adapter`: its `VGA_*` outputs connect straight to the adapter's `x`/`y`/`color`/`write` inputs.

## Interface
Parameters:
- `nX`, 10: X coordinate width.
- `nY`, 9: Y coordinate width.
- `NOBJ`, 2: number of sprites.
- `IDW`, `$clog2(NOBJ)`, minimum 1: object id width.
- `xOBJ`, 4 / `yOBJ`, 4: sprite box is `BOX_X = 2^xOBJ` by `BOX_Y = 2^yOBJ`.
- `COLOR_DEPTH`, 9: pixel colour width.
- `STEP`, 1: pixels moved per move command.
- `XMAX`, 639 / `YMAX`, 479: last visible column/row.
- `X_INIT`, 320 / `Y_INIT`, 240 / `X_SPACE`, 32: reset top-left of object i is (`X_INIT + i*X_SPACE`, `Y_INIT`).
- `BG_COLOR`, 0: colour written when erasing.
- `TRANS_EN`, 1 / `TRANS_COLOR`, all ones: transparency enable and key colour.

Ports:
- `Clock`, in, 1: sole clock, rising edge.
- `Resetn`, in, 1: synchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: engine accepts a command this cycle.
- `cmd_id`, in, `IDW`: target object.
- `cmd_op`, in, 3: 0 SHOW, 1 HIDE, 2 LEFT, 3 RIGHT, 4 UP, 5 DOWN; 6 and 7 are invalid.
- `rom_addr`, out, `IDW+yOBJ+xOBJ`: sprite ROM address `{id, YC, XC}`.
- `rom_data`, in, `COLOR_DEPTH`: ROM pixel, valid one cycle after `rom_addr`.
- `VGA_x`, out, `nX` / `VGA_y`, out, `nY`: pixel coordinate.
- `VGA_color`, out, `COLOR_DEPTH`: pixel colour.
- `VGA_write`, out, 1: pixel write strobe.
- `busy`, out, 1: command in progress (not IDLE).
- `done`, out, 1: one-cycle pulse at command completion.
- `visible`, out, `NOBJ`: per-object visibility flags.

## Operation
- **Per-object state:** position registers `X[i]` (`nX` bits) and `Y[i]` (`nY` bits) hold the top-left corner; `visible[i]`.
- **FSM states:** IDLE, ERASE, MOVE, DRAW, DONE.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch `cmd_id`/`cmd_op`.
  - If the op is valid, go to ERASE when the object is visible and the op is HIDE or a move; otherwise go to MOVE.
  - If the op is invalid (6/7), go directly to DONE.
- **ERASE / DRAW:**
  - `XC`/`YC` scan the box row-major, one pixel per cycle, with no gap between rows.
  - `XC` wraps to 0 and `YC` increments in the same cycle.
  - Each pass lasts `BOX_X*BOX_Y` cycles.
  - ERASE ends after the last pixel and goes to MOVE.
- **MOVE (1 cycle):**
  - Updates the position for move ops.
  - SHOW sets `visible`; HIDE clears it.
  - Goes to DRAW if the object is visible after the op; otherwise goes to DONE.
- **DONE (1 cycle):** `done` = 1, then IDLE.
- **Clamping:** computed in `nX+1`/`nY+1`-bit arithmetic.
  - LEFT: `X = (X < STEP) ? 0 : X-STEP`.
  - RIGHT: `X = min(X+STEP, XMAX+1-BOX_X)`.
  - UP and DOWN follow the same rules using `YMAX`.
  - A clamped move still performs the full erase and redraw.
- **Hidden objects:** moving a hidden object updates its position and writes no pixels. SHOW on a visible object redraws it without erasing. HIDE on a hidden object writes nothing.
- **Pixel output:**
  - `VGA_x = X+XC` and `VGA_y = Y+YC` are registered, as are `write_d` and `erase_d`.
  - `VGA_color = erase_d ? BG_COLOR : rom_data`.
  - `VGA_write = write_d & (erase_d | !TRANS_EN | rom_data != TRANS_COLOR)`.
- **Overlap:** there is no z-order. Erasing may overwrite overlapping sprites; the controller must re-SHOW them.

## Timing
- **Reset values:**
  - Position of object i = (`X_INIT + i*X_SPACE`, `Y_INIT`); `visible` = 0.
  - FSM in IDLE; `cmd_ready` = 0 while `Resetn` = 0, 1 from the first cycle after release.
  - `busy`, `done`, `VGA_write`, `VGA_x`, `VGA_y`, `VGA_color` = 0.
- **Handshake:**
  - A command is accepted on an edge where `cmd_valid & cmd_ready`.
  - `cmd_valid` while busy is ignored; the command is not queued.
- **Latency** (cycle 0 = accept edge, `N = BOX_X*BOX_Y`):
  - Visible move: ERASE cycles 1..N, MOVE N+1, DRAW N+2..2N+1, DONE 2N+2.
  - Pixel writes lag the scan state by one cycle, so the last draw write coincides with DONE.
  - Hidden SHOW: MOVE 1, DRAW 2..N+1, writes 3..N+2, DONE N+2.
  - Hidden move: MOVE 1, DONE 2.
  - Invalid op: DONE 1.
- **Reset mid-operation:** aborts the command immediately. `VGA_write` = 0 from the next cycle and all state returns to reset values.

## Test plan
Test configuration: `NOBJ`=2, `xOBJ`=`yOBJ`=4, `STEP`=4, `X_INIT`=`Y_INIT`=100, `X_SPACE`=64, ROM model returns `{id,YC,XC}[8:0]`, `TRANS_EN`=0 unless noted.
- **Show:** after reset, SHOW id0 → 256 writes from (100,100) to (115,115) in row-major order; `done` at cycle 258; `visible`=01.
- **Visible move:** then RIGHT id0 → 256 writes of colour 0 over x 100..115, then 256 draw writes over x 104..119; `done` at cycle 514.
- **Clamping:** LEFT id0 ×27 → X reaches 0 after the 26th command. The 27th still writes 512 pixels and X stays 0. DOWN id1 repeatedly → Y saturates at 464.
- **Transparency:** `TRANS_EN`=1, ROM returns `TRANS_COLOR` when `XC`<8 → a SHOW produces exactly 128 writes, all with x ≥ X+8.
- **Hidden/invalid ops:** RIGHT id1 while hidden → 0 writes, `done` at cycle 2, X=168. Op 7 → 0 writes, `done` at cycle 1. `cmd_valid` held during a draw → not accepted until `cmd_ready`.
- **Reset mid-draw:** `Resetn` low at cycle 100 of a DRAW → `VGA_write`=0 next cycle, `visible`=00, `cmd_ready`=1 one cycle after release.

Source files
------------

// File: rtl/object_engine_if.sv
// Command channel between keyboard/control logic and object_engine.
// The master issues show/hide/move commands; the engine answers with cmd_ready.
interface object_engine_if #(
    parameter int IDW = 1
) ();
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IDW-1:0] cmd_id;
    logic [2:0]     cmd_op;

    modport master (output cmd_valid, output cmd_id, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_id, input cmd_op, output cmd_ready);
endinterface

// File: rtl/object_engine.sv
// Multi-sprite draw engine: erases, moves/clamps and redraws one of NOBJ sprites per
// command, streaming pixels straight into a vga_adapter-style write port.
module object_engine #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int NOBJ        = 2,
    parameter int IDW         = (NOBJ > 1) ? $clog2(NOBJ) : 1,
    parameter int xOBJ        = 4,
    parameter int yOBJ        = 4,
    parameter int COLOR_DEPTH = 9,
    parameter int STEP        = 1,
    parameter int XMAX        = 639,
    parameter int YMAX        = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int X_SPACE     = 32,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR    = {COLOR_DEPTH{1'b0}},
    parameter bit                     TRANS_EN    = 1'b1,
    parameter logic [COLOR_DEPTH-1:0] TRANS_COLOR = {COLOR_DEPTH{1'b1}}
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    object_engine_if.slave           cmd,
    output logic [IDW+yOBJ+xOBJ-1:0] rom_addr,
    input  logic [COLOR_DEPTH-1:0]   rom_data,
    output logic [nX-1:0]            VGA_x,
    output logic [nY-1:0]            VGA_y,
    output logic [COLOR_DEPTH-1:0]   VGA_color,
    output logic                     VGA_write,
    output logic                     busy,
    output logic                     done,
    output logic [NOBJ-1:0]          visible
);

    localparam logic [2:0] OP_SHOW  = 3'd0;
    localparam logic [2:0] OP_HIDE  = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_UP    = 3'd4;
    localparam logic [2:0] OP_DOWN  = 3'd5;

    // Clamp limits keep the whole box on screen; one extra bit catches the overflow.
    localparam logic [nX:0] X_LIM  = (nX+1)'(XMAX + 1 - (1 << xOBJ));
    localparam logic [nY:0] Y_LIM  = (nY+1)'(YMAX + 1 - (1 << yOBJ));
    localparam logic [nX:0] STEP_X = (nX+1)'(STEP);
    localparam logic [nY:0] STEP_Y = (nY+1)'(STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_MOVE  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic                   ready_r;
    logic [IDW-1:0]         id_r;
    logic [2:0]             op_r;
    logic [xOBJ-1:0]        xc_r;
    logic [yOBJ-1:0]        yc_r;
    logic [nX-1:0]          x_r [NOBJ];
    logic [nY-1:0]          y_r [NOBJ];
    logic [NOBJ-1:0]        vis_r;
    logic                   write_d_r, erase_d_r;
    logic [nX-1:0]          vga_x_r;
    logic [nY-1:0]          vga_y_r;

    logic                   accept_s, scanning_s, scan_last_s, vis_after_s;
    logic [nX-1:0]          cur_x_s, new_x_s;
    logic [nY-1:0]          cur_y_s, new_y_s;
    logic [nX:0]            ext_x_s, sum_x_s;
    logic [nY:0]            ext_y_s, sum_y_s;

    assign accept_s    = (state_r == S_IDLE) && cmd.cmd_valid && ready_r;
    assign scanning_s  = (state_r == S_ERASE) || (state_r == S_DRAW);
    assign scan_last_s = (&xc_r) && (&yc_r);
    assign cur_x_s     = x_r[id_r];
    assign cur_y_s     = y_r[id_r];
    assign ext_x_s     = {1'b0, cur_x_s};
    assign ext_y_s     = {1'b0, cur_y_s};
    assign sum_x_s     = ext_x_s + STEP_X;
    assign sum_y_s     = ext_y_s + STEP_Y;

    // Position/visibility the latched command produces, applied in MOVE.
    always_comb begin
        new_x_s     = cur_x_s;
        new_y_s     = cur_y_s;
        vis_after_s = vis_r[id_r];
        case (op_r)
            OP_SHOW:  vis_after_s = 1'b1;
            OP_HIDE:  vis_after_s = 1'b0;
            OP_LEFT:  new_x_s = (ext_x_s < STEP_X) ? {nX{1'b0}} : nX'(ext_x_s - STEP_X);
            OP_RIGHT: new_x_s = (sum_x_s > X_LIM) ? nX'(X_LIM) : nX'(sum_x_s);
            OP_UP:    new_y_s = (ext_y_s < STEP_Y) ? {nY{1'b0}} : nY'(ext_y_s - STEP_Y);
            OP_DOWN:  new_y_s = (sum_y_s > Y_LIM) ? nY'(Y_LIM) : nY'(sum_y_s);
            default:  vis_after_s = vis_r[id_r];
        endcase
    end

    // Next-state logic; only a visible object erased by HIDE or a move needs ERASE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!accept_s) begin
                    state_s = S_IDLE;
                end else if (cmd.cmd_op > OP_DOWN) begin
                    state_s = S_DONE;
                end else if (vis_r[cmd.cmd_id] && (cmd.cmd_op != OP_SHOW)) begin
                    state_s = S_ERASE;
                end else begin
                    state_s = S_MOVE;
                end
            end
            S_ERASE: state_s = scan_last_s ? S_MOVE : S_ERASE;
            S_MOVE:  state_s = vis_after_s ? S_DRAW : S_DONE;
            S_DRAW:  state_s = scan_last_s ? S_DONE : S_DRAW;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register, command latch and registered ready.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r <= S_IDLE;
            ready_r <= 1'b0;
            id_r    <= {IDW{1'b0}};
            op_r    <= 3'd0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == S_IDLE);
            if (accept_s) begin
                id_r <= cmd.cmd_id;
                op_r <= cmd.cmd_op;
            end
        end
    end

    // Row-major box scan; the counters naturally wrap to zero at the end of a pass.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            xc_r <= {xOBJ{1'b0}};
            yc_r <= {yOBJ{1'b0}};
        end else if (scanning_s) begin
            xc_r <= xc_r + xOBJ'(1);
            if (&xc_r) begin
                yc_r <= yc_r + yOBJ'(1);
            end
        end else begin
            xc_r <= {xOBJ{1'b0}};
            yc_r <= {yOBJ{1'b0}};
        end
    end

    // Per-object position and visibility.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < NOBJ; i++) begin
                x_r[i] <= nX'(X_INIT + i * X_SPACE);
                y_r[i] <= nY'(Y_INIT);
            end
            vis_r <= {NOBJ{1'b0}};
        end else if (state_r == S_MOVE) begin
            x_r[id_r]   <= new_x_s;
            y_r[id_r]   <= new_y_s;
            vis_r[id_r] <= vis_after_s;
        end
    end

    // Pixel stage, delayed one cycle so it lines up with the synchronous ROM read.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            write_d_r <= 1'b0;
            erase_d_r <= 1'b0;
            vga_x_r   <= {nX{1'b0}};
            vga_y_r   <= {nY{1'b0}};
        end else begin
            write_d_r <= scanning_s;
            erase_d_r <= (state_r == S_ERASE);
            if (scanning_s) begin
                vga_x_r <= cur_x_s + nX'(xc_r);
                vga_y_r <= cur_y_s + nY'(yc_r);
            end
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign rom_addr      = {id_r, yc_r, xc_r};
    assign VGA_x         = vga_x_r;
    assign VGA_y         = vga_y_r;
    assign VGA_color     = erase_d_r ? BG_COLOR : rom_data;
    assign VGA_write     = write_d_r & (erase_d_r | ~TRANS_EN | (rom_data != TRANS_COLOR));
    assign busy          = (state_r != S_IDLE);
    assign done          = (state_r == S_DONE);
    assign visible       = vis_r;

endmodule

// File: tb/tb_object_engine.sv
// Self-checking bench for object_engine: a command table plus hand-written corner
// sequences, with expected pixel writes queued at issue time and popped per write.
module tb_object_engine;

    localparam int OP_SHOW = 0, OP_HIDE = 1, OP_LEFT = 2, OP_RIGHT = 3, OP_UP = 4, OP_DOWN = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    object_engine_if #(.IDW(1)) cmd_m ();
    object_engine_if #(.IDW(1)) cmd_t ();

    logic [8:0] rom_addr_m, rom_data_m, rom_addr_t, rom_data_t;
    logic [9:0] x_m, x_t;
    logic [8:0] y_m, y_t, c_m, c_t;
    logic       w_m, w_t, busy_m, busy_t, done_m, done_t;
    logic [1:0] vis_m, vis_t;

    object_engine #(.nX(10), .nY(9), .NOBJ(2), .xOBJ(4), .yOBJ(4), .COLOR_DEPTH(9), .STEP(4),
        .XMAX(639), .YMAX(479), .X_INIT(100), .Y_INIT(100), .X_SPACE(64),
        .BG_COLOR(9'd0), .TRANS_EN(1'b0), .TRANS_COLOR(9'h1FF)) dut_m (
        .Clock(clk), .Resetn(rstn), .cmd(cmd_m), .rom_addr(rom_addr_m), .rom_data(rom_data_m),
        .VGA_x(x_m), .VGA_y(y_m), .VGA_color(c_m), .VGA_write(w_m),
        .busy(busy_m), .done(done_m), .visible(vis_m));

    object_engine #(.nX(10), .nY(9), .NOBJ(2), .xOBJ(4), .yOBJ(4), .COLOR_DEPTH(9), .STEP(4),
        .XMAX(639), .YMAX(479), .X_INIT(100), .Y_INIT(100), .X_SPACE(64),
        .BG_COLOR(9'd0), .TRANS_EN(1'b1), .TRANS_COLOR(9'h1FF)) dut_t (
        .Clock(clk), .Resetn(rstn), .cmd(cmd_t), .rom_addr(rom_addr_t), .rom_data(rom_data_t),
        .VGA_x(x_t), .VGA_y(y_t), .VGA_color(c_t), .VGA_write(w_t),
        .busy(busy_t), .done(done_t), .visible(vis_t));

    // Sprite ROMs: pixel = {id,YC,XC}; the second one is transparent for XC < 8.
    always @(posedge clk) rom_data_m <= rom_addr_m;
    always @(posedge clk) rom_data_t <= (rom_addr_t[3:0] < 4'd8) ? 9'h1FF : rom_addr_t;

    bit         sel;
    logic [9:0] obs_x;
    logic [8:0] obs_y, obs_c;
    logic       obs_w, obs_busy, obs_done, obs_ready;
    logic [1:0] obs_vis;
    assign obs_x     = sel ? x_t : x_m;
    assign obs_y     = sel ? y_t : y_m;
    assign obs_c     = sel ? c_t : c_m;
    assign obs_w     = sel ? w_t : w_m;
    assign obs_busy  = sel ? busy_t : busy_m;
    assign obs_done  = sel ? done_t : done_m;
    assign obs_ready = sel ? cmd_t.cmd_ready : cmd_m.cmd_ready;
    assign obs_vis   = sel ? vis_t : vis_m;

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct { int id; int op; bit er; bit dr; int lat; int nx; int ny; int vis; } vec_t;

    pix_t exp_q[$];
    vec_t vecs[$];
    vec_t v;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   pos_x[2];
    int   pos_y[2];
    int   cyc, rdy_busy;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(int id, int op, bit er, bit dr, int lat, int nx, int ny, int vis);
        vec_t r;
        r.id = id; r.op = op; r.er = er; r.dr = dr; r.lat = lat; r.nx = nx; r.ny = ny; r.vis = vis;
        vecs.push_back(r);
    endfunction

    task automatic push_box(int id, int bx, int by, bit erase, bit trans);
        pix_t p;
        for (int yc = 0; yc < 16; yc++) begin
            for (int xc = 0; xc < 16; xc++) begin
                if (!(trans && xc < 8)) begin
                    p.x = bx + xc;
                    p.y = by + yc;
                    p.c = erase ? 0 : (id * 256 + yc * 16 + xc);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // One cycle: step to the negedge and score any pixel write against the queue.
    task automatic observe();
        pix_t p;
        @(negedge clk);
        if (obs_w) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(obs_w), 0);
            end else begin
                p = exp_q.pop_front();
                n_checks++;
                if (obs_x != p.x || obs_y != p.y || obs_c != p.c) begin
                    n_fails++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0h, expected x=%0d y=%0d c=%0h",
                             obs_x, obs_y, obs_c, p.x, p.y, p.c);
                end
            end
        end
    endtask

    // Called just after a negedge; returns right after the accept edge.
    task automatic send(bit s, int id, int op);
        int guard;
        sel   = s;
        guard = 0;
        while (!obs_ready && guard < 1000) begin
            observe();
            guard++;
        end
        if (guard >= 1000) check("ready_timeout", int'(obs_ready), 1);
        if (s) begin
            cmd_t.cmd_valid = 1'b1; cmd_t.cmd_id = 1'(id); cmd_t.cmd_op = 3'(op);
        end else begin
            cmd_m.cmd_valid = 1'b1; cmd_m.cmd_id = 1'(id); cmd_m.cmd_op = 3'(op);
        end
        @(posedge clk);
    endtask

    task automatic wait_done(int lat, string name);
        int c;
        c = 0;
        do begin
            observe();
            c++;
            if (c == 1) begin
                cmd_m.cmd_valid = 1'b0;
                cmd_t.cmd_valid = 1'b0;
            end
        end while (!obs_done && c < 2000);
        check({name, "_latency"}, c, lat);
        observe();
        check({name, "_missing_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        sel = 1'b0;
        rstn = 1'b0;
        cmd_m.cmd_valid = 1'b0; cmd_m.cmd_id = 1'b0; cmd_m.cmd_op = 3'd0;
        cmd_t.cmd_valid = 1'b0; cmd_t.cmd_id = 1'b0; cmd_t.cmd_op = 3'd0;
        pos_x[0] = 100; pos_x[1] = 164; pos_y[0] = 100; pos_y[1] = 100;

        add(0, OP_SHOW,  0, 1, 258, 100, 100, 1);
        add(0, OP_RIGHT, 1, 1, 514, 104, 100, 1);
        for (int k = 1; k <= 27; k++)
            add(0, OP_LEFT, 1, 1, 514, (104 - 4 * k < 0) ? 0 : 104 - 4 * k, 100, 1);
        add(1, OP_RIGHT, 0, 0, 2, 168, 100, 1);
        for (int k = 1; k <= 93; k++)
            add(1, OP_DOWN, 0, 0, 2, 168, (100 + 4 * k > 464) ? 464 : 100 + 4 * k, 1);
        add(1, OP_SHOW,  0, 1, 258, 168, 464, 3);
        add(1, OP_DOWN,  1, 1, 514, 168, 464, 3);
        add(0, 7,        0, 0, 1,   0,   100, 3);
        add(1, 6,        0, 0, 1,   168, 464, 3);
        add(0, OP_HIDE,  1, 0, 258, 0,   100, 2);
        add(0, OP_HIDE,  0, 0, 2,   0,   100, 2);
        add(1, OP_SHOW,  0, 1, 258, 168, 464, 2);
        add(1, OP_UP,    1, 1, 514, 168, 460, 2);

        repeat (4) @(negedge clk);
        check("rst_ready", int'(obs_ready), 0);
        check("rst_busy", int'(obs_busy), 0);
        check("rst_done", int'(obs_done), 0);
        check("rst_write", int'(obs_w), 0);
        check("rst_x", int'(obs_x), 0);
        check("rst_y", int'(obs_y), 0);
        check("rst_color", int'(obs_c), 0);
        check("rst_visible", int'(obs_vis), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(obs_ready), 1);

        foreach (vecs[k]) begin
            v = vecs[k];
            if (v.er) push_box(v.id, pos_x[v.id], pos_y[v.id], 1'b1, 1'b0);
            if (v.dr) push_box(v.id, v.nx, v.ny, 1'b0, 1'b0);
            pos_x[v.id] = v.nx;
            pos_y[v.id] = v.ny;
            send(1'b0, v.id, v.op);
            wait_done(v.lat, $sformatf("row%0d", k));
            check($sformatf("row%0d_visible", k), int'(obs_vis), v.vis);
        end

        // cmd_valid held through a draw must wait for the engine to return to IDLE.
        push_box(0, 0, 100, 1'b0, 1'b0);
        send(1'b0, 0, OP_SHOW);
        cyc = 0; rdy_busy = 0;
        do begin
            observe();
            cyc++;
            if (cyc == 1) cmd_m.cmd_op = 3'(OP_RIGHT);
            if (obs_ready) rdy_busy++;
        end while (!obs_done && cyc < 1000);
        check("hold_show_latency", cyc, 258);
        check("hold_ready_while_busy", rdy_busy, 0);
        push_box(0, 0, 100, 1'b1, 1'b0);
        push_box(0, 4, 100, 1'b0, 1'b0);
        observe();
        check("hold_ready_after_done", int'(obs_ready), 1);
        @(posedge clk);
        wait_done(514, "hold_move");
        check("hold_visible", int'(obs_vis), 3);

        // Reset at DRAW cycle 100 of a redraw of id1.
        push_box(1, 168, 460, 1'b0, 1'b0);
        send(1'b0, 1, OP_SHOW);
        for (int k = 0; k < 101; k++) begin
            observe();
            if (k == 0) cmd_m.cmd_valid = 1'b0;
        end
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_write", int'(obs_w), 0);
        check("midrst_busy", int'(obs_busy), 0);
        check("midrst_done", int'(obs_done), 0);
        check("midrst_visible", int'(obs_vis), 0);
        check("midrst_ready", int'(obs_ready), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_ready_after_release", int'(obs_ready), 1);
        pos_x[0] = 100; pos_x[1] = 164; pos_y[0] = 100; pos_y[1] = 100;
        push_box(0, 100, 100, 1'b0, 1'b0);
        send(1'b0, 0, OP_SHOW);
        wait_done(258, "post_rst_show0");
        push_box(1, 164, 100, 1'b0, 1'b0);
        send(1'b0, 1, OP_SHOW);
        wait_done(258, "post_rst_show1");
        check("post_rst_visible", int'(obs_vis), 3);

        // Transparency: only the right half of each row reaches the screen.
        push_box(0, 100, 100, 1'b0, 1'b1);
        send(1'b1, 0, OP_SHOW);
        wait_done(258, "trans_show");
        check("trans_visible", int'(obs_vis), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
